alu_exec_seq: RTL and testbench

- Parametrised successor to the combinational ALU control decoder: decodes alu_op/funct3/funct7 into a 4-bit operation code and executes it on XLEN-bit operands.
- Registered valid/ready handshake on input and output.
- Single-cycle ops complete in 1 clock; unsigned/low multiply runs on an iterative shift-add engine over XLEN clocks.
- Sits in the EX stage between the operand muxes and the EX/MEM register.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_decode.sv | 40 ++++
 rtl/alu_exec_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_exec_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential EX-stage ALU: operation codes,
// FSM states, alu_op / funct7 encodings and the common funct3 decode table.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SLL     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SUB     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_SLT     = 4'b1000,
    ALU_SLTU    = 4'b1001,
    ALU_MUL     = 4'b1010,
    ALU_MULHU   = 4'b1011,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  localparam logic [1:0] ALU_OP_LS = 2'b00;
  localparam logic [1:0] ALU_OP_BR = 2'b01;
  localparam logic [1:0] ALU_OP_R  = 2'b10;
  localparam logic [1:0] ALU_OP_I  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Base-encoding funct3 table shared by R-type and I-type instructions.
  function automatic alu_op_e baseOp(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder from alu_op/funct3/funct7 to an ALU operation code.
// The MUL/MULHU encodings are recognised only when ALU_MUL_EN is defined.
module alu_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_e    op_o
);

  always_comb begin
    op_o = ALU_ILLEGAL;
    case (alu_op_i)
      ALU_OP_LS: op_o = ALU_ADD;
      ALU_OP_BR: op_o = ALU_SUB;
      ALU_OP_R: begin
        if (funct7_i == F7_BASE) begin
          op_o = baseOp(funct3_i);
        end else if (funct7_i == F7_ALT) begin
          if (funct3_i == 3'b000)      op_o = ALU_SUB;
          else if (funct3_i == 3'b101) op_o = ALU_SRA;
        end
`ifdef ALU_MUL_EN
        else if (funct7_i == F7_MULDIV) begin
          if (funct3_i == 3'b000)      op_o = ALU_MUL;
          else if (funct3_i == 3'b011) op_o = ALU_MULHU;
        end
`endif
      end
      ALU_OP_I: begin
        // Immediates occupy funct7 except for the shift encodings.
        op_o = baseOp(funct3_i);
        if (funct3_i == 3'b101 && funct7_i[5]) op_o = ALU_SRA;
        if (funct3_i == 3'b001 && funct7_i != F7_BASE) op_o = ALU_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// EX-stage ALU with valid/ready handshake: single-cycle ops in one clock and,
// when ALU_MUL_EN is defined, an iterative shift-add multiplier for MUL/MULHU.
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  if (XLEN < 8 || XLEN > 64 || CNT_W != $clog2(XLEN) + 1) begin : g_badParam
    $error("alu_exec_seq: XLEN must be 8..64 and CNT_W left at its derived value");
  end

  alu_op_e         opCode;
  state_e          state_q, state_d;
  logic            accept, isMul;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] aluRes, result_q, result_d;
  logic            zero_q, zero_d, illegal_q, illegal_d;

  alu_decode u_decode (
    .alu_op_i (alu_op),
    .funct3_i (funct3),
    .funct7_i (funct7),
    .op_o     (opCode)
  );

  assign shamt  = op_b[SHW-1:0];
  assign accept = in_valid & in_ready & ~flush;

  always_comb begin
    aluRes = '0;
    case (opCode)
      ALU_AND:  aluRes = op_a & op_b;
      ALU_OR:   aluRes = op_a | op_b;
      ALU_ADD:  aluRes = op_a + op_b;
      ALU_XOR:  aluRes = op_a ^ op_b;
      ALU_SLL:  aluRes = op_a << shamt;
      ALU_SRL:  aluRes = op_a >> shamt;
      ALU_SUB:  aluRes = op_a - op_b;
      ALU_SRA:  aluRes = $signed(op_a) >>> shamt;
      ALU_SLT:  aluRes = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: aluRes = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:  aluRes = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] acc_q, mcand_q, accSum;
  logic [XLEN-1:0]   mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mulHigh_q, mulDone;

  assign isMul   = (opCode == ALU_MUL) || (opCode == ALU_MULHU);
  assign accSum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mulDone = (state_q == ST_MUL) && (cnt_q == CNT_W'(1));

  // One multiplier bit per clock; the multiplicand walks left as the multiplier walks right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      mulHigh_q <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept && isMul) begin
      acc_q     <= '0;
      mcand_q   <= {{XLEN{1'b0}}, op_a};
      mplier_q  <= op_b;
      cnt_q     <= CNT_W'(XLEN);
      mulHigh_q <= (opCode == ALU_MULHU);
    end else if (state_q == ST_MUL) begin
      acc_q    <= accSum;
      mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end
`else
  assign isMul = 1'b0;
`endif

  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (accept && !isMul) begin
      result_d  = aluRes;
      zero_d    = (aluRes == '0);
      illegal_d = (opCode == ALU_ILLEGAL);
    end
`ifdef ALU_MUL_EN
    else if (!flush && mulDone) begin
      result_d  = mulHigh_q ? accSum[2*XLEN-1:XLEN] : accSum[XLEN-1:0];
      zero_d    = (result_d == '0);
      illegal_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept)                          state_d = isMul ? ST_MUL : ST_HOLD;
          else if (state_q == ST_HOLD && out_ready) state_d = ST_IDLE;
        end
`ifdef ALU_MUL_EN
        ST_MUL: if (mulDone) state_d = ST_HOLD;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready);
    out_valid = (state_q == ST_HOLD);
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed vectors with literal
// expectations plus a queue-based reference model checked on every valid cycle.
module tb_alu_exec_seq;

  localparam int XLEN = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      alu_op = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic [6:0]      funct7 = 7'b0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  alu_exec_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
    nCompared++;
    if (got !== expv) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  // Reference model: instruction fields and operands straight to the architectural answer.
  function automatic exp_t modelOp(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] prod;
    logic [63:0] sext;
    int sh;
    e.res = '0;
    e.ill = 1'b0;
    sh    = int'(b[4:0]);
    prod  = {32'b0, a} * {32'b0, b};
    sext  = {{32{a[31]}}, a} >> sh;
    if (aop == 2'b00) e.res = a + b;
    else if (aop == 2'b01) e.res = a - b;
    else if (aop == 2'b10 && f7 == 7'h01) begin
      if (MUL_EN && f3 == 3'd0)      e.res = prod[31:0];
      else if (MUL_EN && f3 == 3'd3) e.res = prod[63:32];
      else                           e.ill = 1'b1;
    end else if (aop == 2'b10 && f7 == 7'h20) begin
      if (f3 == 3'd0)      e.res = a - b;
      else if (f3 == 3'd5) e.res = sext[31:0];
      else                 e.ill = 1'b1;
    end else if (aop == 2'b10 && f7 != 7'h00) begin
      e.ill = 1'b1;
    end else begin
      case (f3)
        3'd0: e.res = a + b;
        3'd1: if (aop == 2'b11 && f7 != 7'h00) e.ill = 1'b1; else e.res = a << sh;
        3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
        3'd4: e.res = a ^ b;
        3'd5: e.res = (aop == 2'b11 && f7[5]) ? sext[31:0] : (a >> sh);
        3'd6: e.res = a | b;
        default: e.res = a & b;
      endcase
    end
    return e;
  endfunction

  // Compare process: every valid cycle is checked against the oldest accepted request.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      checkOutput("reset out_valid", out_valid, 0);
    end else begin
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected out_valid", out_valid, 0);
        end else begin
          checkOutput("model result", result, expQ[0].res);
          checkOutput("model zero", zero, expQ[0].res == 32'd0);
          checkOutput("model illegal", illegal, expQ[0].ill);
          if (out_ready) void'(expQ.pop_front());
        end
      end
      if (flush) expQ.delete();
      else if (in_valid && in_ready) expQ.push_back(modelOp(alu_op, funct3, funct7, op_a, op_b));
    end
  end

  task automatic applyStimulus(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b);
    bit took = 1'b0;
    alu_op = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    op_a = 32'hDEADBEEF;
    op_b = 32'h0BADF00D;
    checkOutput("accept handshake", took, 1);
  endtask

  task automatic waitValid(output int lat, output bit sawReady);
    lat = 1;
    sawReady = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) sawReady = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runVector(input string name, input logic [1:0] aop, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expRes, input logic expIll, input int expLat);
    int lat;
    bit sawReady;
    applyStimulus(aop, f3, f7, a, b);
    waitValid(lat, sawReady);
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " result"}, result, expRes);
    checkOutput({name, " zero"}, zero, expRes == 32'd0);
    checkOutput({name, " illegal"}, illegal, expIll);
    if (expLat > 1) checkOutput({name, " busy in_ready"}, sawReady, 0);
  endtask

  logic [31:0] bA [4] = '{32'd1, 32'd10, 32'hFFFFFFFF, 32'd100};
  logic [31:0] bB [4] = '{32'd2, 32'd20, 32'd1, 32'd200};
  logic [31:0] bE [4] = '{32'd3, 32'd30, 32'd0, 32'd300};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawValid;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset result", result, 0);
    checkOutput("reset zero", zero, 0);
    checkOutput("reset illegal", illegal, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle in_ready", in_ready, 1);
    checkOutput("idle out_valid", out_valid, 0);
    checkOutput("idle zero", zero, 0);

    runVector("R sub",     2'b10, 3'b000, 7'h20, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1);
    runVector("srai",      2'b11, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
    runVector("srli",      2'b11, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
    runVector("sll shamt", 2'b10, 3'b001, 7'h00, 32'd1,        32'h24,       32'h10,       1'b0, 1);
    runVector("slt",       2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
    runVector("sltu",      2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
    runVector("xor",       2'b10, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);
    runVector("or",        2'b10, 3'b110, 7'h00, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1);
    runVector("and",       2'b10, 3'b111, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
    runVector("branch eq", 2'b01, 3'b000, 7'h00, 32'd3,        32'd3,        32'd0,        1'b0, 1);
    runVector("ls wrap",   2'b00, 3'b111, 7'h7F, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1);
    runVector("sra max",   2'b10, 3'b101, 7'h20, 32'h80000000, 32'h3F,       32'hFFFFFFFF, 1'b0, 1);
    runVector("slli bad",  2'b11, 3'b001, 7'h01, 32'd1,        32'd1,        32'd0,        1'b1, 1);
    runVector("R alt bad", 2'b10, 3'b001, 7'h20, 32'd1,        32'd1,        32'd0,        1'b1, 1);
`ifdef ALU_MUL_EN
    runVector("mul",       2'b10, 3'b000, 7'h01, 32'h12345678, 32'h10,       32'h23456780, 1'b0, 33);
    runVector("mulhu max", 2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    runVector("mulh bad",  2'b10, 3'b001, 7'h01, 32'd6,        32'd7,        32'd0,        1'b1, 1);
`else
    runVector("mul off",   2'b10, 3'b000, 7'h01, 32'd6,        32'd7,        32'd0,        1'b1, 1);
`endif

    // Back-to-back ADDs, one per clock, then a stalled consumer.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00;
      op_a = bA[k]; op_b = bB[k]; in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("b2b out_valid", out_valid, 1);
      checkOutput("b2b result", result, bE[k]);
      checkOutput("b2b in_ready", in_ready, 1);
    end
    out_ready = 1'b0;
    op_a = 32'h1000; op_b = 32'h234;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall result", result, 32'd300);
      checkOutput("stall in_ready", in_ready, 0);
      checkOutput("stall out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("after stall result", result, 32'h1234);
    @(posedge clk);
    #1;
    checkOutput("drain out_valid", out_valid, 0);

    // Flush while a result is held drops it and any same-cycle request.
    out_ready = 1'b0;
    applyStimulus(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
    checkOutput("pre-flush out_valid", out_valid, 1);
    flush = 1'b1;
    in_valid = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush out_valid", out_valid, 0);
    checkOutput("flush in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("flush dropped", out_valid, 0);
    out_ready = 1'b1;

`ifdef ALU_MUL_EN
    applyStimulus(2'b10, 3'b000, 7'h01, 32'h12345678, 32'h10);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("mul flush out_valid", out_valid, 0);
    checkOutput("mul flush in_ready", in_ready, 1);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("mul flush never valid", sawValid, 0);
`endif

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    applyStimulus(2'b00, 3'b000, 7'h00, 32'd7, 32'd9);
    checkOutput("pre-reset result", result, 32'd16);
    rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", out_valid, 0);
    checkOutput("async rst result", result, 0);
    checkOutput("async rst zero", zero, 0);
    checkOutput("async rst illegal", illegal, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;

`ifdef ALU_MUL_EN
    applyStimulus(2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("mul rst out_valid", out_valid, 0);
    checkOutput("mul rst result", result, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("mul rst no partial", sawValid, 0);
`endif

    runVector("post reset add", 2'b00, 3'b000, 7'h00, 32'd40, 32'd2, 32'd42, 1'b0, 1);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
